// File: rtl/binary_op_arbiter.sv
// Round-robin arbiter sharing one fixed-latency binary-operation pipeline among requesters.
// Optional registered output stage: define BINARY_OP_ARB_OUTPUT_REG_EN (adds one cycle of latency).

module binary_op_arbiter #(
  parameter int unsigned ParamNumReq   = 4,
  parameter int unsigned ParamBitWidth = 32,
  parameter int unsigned ParamLatency  = 2
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   enable_i,
  input  logic [ParamNumReq-1:0]                 req_valid_i,
  output logic [ParamNumReq-1:0]                 req_ready_o,
  input  logic [4*ParamNumReq-1:0]               req_op_i,
  input  logic [ParamBitWidth*ParamNumReq-1:0]   req_lhs_i,
  input  logic [ParamBitWidth*ParamNumReq-1:0]   req_rhs_i,
  output logic [ParamNumReq-1:0]                 rsp_valid_o,
  output logic [ParamBitWidth-1:0]               rsp_data_o,
  output logic                                   busy_o
);

  localparam int unsigned IdW = $clog2(ParamNumReq);
  localparam int unsigned W   = ParamBitWidth;
  localparam logic [W-1:0] WidthVec = W'(ParamBitWidth);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpMul  = 4'd2;
  localparam logic [3:0] OpLshr = 4'd3;
  localparam logic [3:0] OpAshr = 4'd4;
  localparam logic [3:0] OpShl  = 4'd5;
  localparam logic [3:0] OpOr   = 4'd6;
  localparam logic [3:0] OpAnd  = 4'd7;
  localparam logic [3:0] OpXor  = 4'd8;

  function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base,
                                               input int unsigned    off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= ParamNumReq) s = s - ParamNumReq;
    return IdW'(s);
  endfunction

  // Arbitration
  logic [IdW-1:0] ptr_q, ptr_d;
  logic           grant_found;
  logic [IdW-1:0] grant_idx;
  logic           accept;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < ParamNumReq; k++) begin
      if (!grant_found && req_valid_i[wrap_add(ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  assign accept = grant_found & enable_i & ~reset_i;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  assign ptr_d = accept ? wrap_add(grant_idx, 1) : ptr_q;

  // Operand selection and datapath
  logic [3:0]          op_sel;
  logic [W-1:0]        lhs_sel;
  logic [W-1:0]        rhs_sel;
  logic                shamt_big;
  logic signed [W-1:0] ashr_res;
  logic [W-1:0]        alu_res;

  assign op_sel    = req_op_i[32'(grant_idx)*4 +: 4];
  assign lhs_sel   = req_lhs_i[32'(grant_idx)*W +: W];
  assign rhs_sel   = req_rhs_i[32'(grant_idx)*W +: W];
  assign shamt_big = (rhs_sel >= WidthVec);
  assign ashr_res  = $signed(lhs_sel) >>> rhs_sel;

  always_comb begin
    alu_res = '0;
    unique case (op_sel)
      OpAdd:   alu_res = lhs_sel + rhs_sel;
      OpSub:   alu_res = lhs_sel - rhs_sel;
      // Low W bits of a product are identical for signed and unsigned operands.
      OpMul:   alu_res = lhs_sel * rhs_sel;
      OpLshr:  alu_res = shamt_big ? '0 : (lhs_sel >> rhs_sel);
      OpAshr: begin
        if (shamt_big) alu_res = {W{lhs_sel[W-1]}};
        else           alu_res = ashr_res;
      end
      OpShl:   alu_res = shamt_big ? '0 : (lhs_sel << rhs_sel);
      OpOr:    alu_res = lhs_sel | rhs_sel;
      OpAnd:   alu_res = lhs_sel & rhs_sel;
      OpXor:   alu_res = lhs_sel ^ rhs_sel;
      default: alu_res = '0;
    endcase
  end

  // Pipeline stages: result computed into stage 0, carried unchanged afterwards
  logic [ParamLatency-1:0] stg_vld_q, stg_vld_d;
  logic [IdW-1:0]          stg_id_q   [ParamLatency];
  logic [IdW-1:0]          stg_id_d   [ParamLatency];
  logic [W-1:0]            stg_data_q [ParamLatency];
  logic [W-1:0]            stg_data_d [ParamLatency];

  always_comb begin
    stg_vld_d  = stg_vld_q;
    stg_id_d   = stg_id_q;
    stg_data_d = stg_data_q;
    if (enable_i) begin
      stg_vld_d[0] = accept;
      if (accept) begin
        stg_id_d[0]   = grant_idx;
        stg_data_d[0] = alu_res;
      end
      for (int unsigned s = 1; s < ParamLatency; s++) begin
        stg_vld_d[s]  = stg_vld_q[s-1];
        stg_id_d[s]   = stg_id_q[s-1];
        stg_data_d[s] = stg_data_q[s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q     <= '0;
      stg_vld_q <= '0;
      for (int unsigned s = 0; s < ParamLatency; s++) begin
        stg_id_q[s]   <= '0;
        stg_data_q[s] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      stg_vld_q <= stg_vld_d;
      for (int unsigned s = 0; s < ParamLatency; s++) begin
        stg_id_q[s]   <= stg_id_d[s];
        stg_data_q[s] <= stg_data_d[s];
      end
    end
  end

`ifdef BINARY_OP_ARB_OUTPUT_REG_EN
  logic           out_vld_q, out_vld_d;
  logic [IdW-1:0] out_id_q, out_id_d;
  logic [W-1:0]   out_data_q, out_data_d;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_id_d   = out_id_q;
    out_data_d = out_data_q;
    if (enable_i) begin
      out_vld_d  = stg_vld_q[ParamLatency-1];
      out_id_d   = stg_id_q[ParamLatency-1];
      out_data_d = stg_data_q[ParamLatency-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_vld_q  <= 1'b0;
      out_id_q   <= '0;
      out_data_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_id_q   <= out_id_d;
      out_data_q <= out_data_d;
    end
  end

  // A held result stays silent while stalled and strobes once enable returns.
  always_comb begin
    rsp_valid_o = '0;
    if (out_vld_q && enable_i) rsp_valid_o[out_id_q] = 1'b1;
  end

  assign rsp_data_o = out_data_q;
  assign busy_o     = (|stg_vld_q) | out_vld_q;
`else
  always_comb begin
    rsp_valid_o = '0;
    if (stg_vld_q[ParamLatency-1] && enable_i) rsp_valid_o[stg_id_q[ParamLatency-1]] = 1'b1;
  end

  assign rsp_data_o = stg_data_q[ParamLatency-1];
  assign busy_o     = |stg_vld_q;
`endif

endmodule

// File: tb/tb_binary_op_arbiter.sv
// Scoreboard bench for binary_op_arbiter: directed scenarios followed by randomized traffic.

module tb_binary_op_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 2;
`ifdef BINARY_OP_ARB_OUTPUT_REG_EN
  localparam int Lat = L + 1;
`else
  localparam int Lat = L;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             enable;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [4*N-1:0]   req_op;
  logic [W*N-1:0]   req_lhs;
  logic [W*N-1:0]   req_rhs;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_data;
  logic             busy;

  logic [3:0]   op_a  [N];
  logic [W-1:0] lhs_a [N];
  logic [W-1:0] rhs_a [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_op[4*g +: 4]  = op_a[g];
    assign req_lhs[W*g +: W] = lhs_a[g];
    assign req_rhs[W*g +: W] = rhs_a[g];
  end

  binary_op_arbiter #(
    .ParamNumReq   (N),
    .ParamBitWidth (W),
    .ParamLatency  (L)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (enable),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_lhs_i   (req_lhs),
    .req_rhs_i   (req_rhs),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy)
  );

  // cnt = enabled clock edges still needed before the response is visible
  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mptr   = 0;
  int   mgrant = -1;

  function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    logic [W-1:0]   fill;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: begin
        prod = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        return prod[W-1:0];
      end
      4'd3: begin
        if (b >= W) return '0;
        return a >> b;
      end
      4'd4: begin
        if (b >= W) return {W{a[W-1]}};
        fill = a[W-1] ? ~({W{1'b1}} >> b) : '0;
        return (a >> b) | fill;
      end
      4'd5: begin
        if (b >= W) return '0;
        return a << b;
      end
      4'd6: return a | b;
      4'd7: return a & b;
      4'd8: return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Monitor: compares DUT responses against the scoreboard front
  always @(negedge clk) begin : monitor
    logic [N-1:0] exp_v;
    logic [W-1:0] exp_d;
    logic         has;
    if (!reset) begin
      exp_v = '0;
      exp_d = '0;
      has   = 1'b0;
      checks++;
      if (busy !== (q.size() != 0)) begin
        errors++;
        $display("FAIL busy: got %0b expected %0b at %0t", busy, q.size() != 0, $time);
      end
      if (q.size() > 0 && q[0].cnt == 0 && enable) begin
        exp_v[q[0].id] = 1'b1;
        exp_d          = q[0].data;
        has            = 1'b1;
      end
      checks++;
      if (rsp_valid !== exp_v) begin
        errors++;
        $display("FAIL rsp_valid: got %b expected %b at %0t", rsp_valid, exp_v, $time);
      end
      if (has) begin
        checks++;
        if (rsp_data !== exp_d) begin
          errors++;
          $display("FAIL rsp_data: got %h expected %h at %0t", rsp_data, exp_d, $time);
        end
        void'(q.pop_front());
      end
    end
  end

  // Issue side: model arbitration, check grants, push expected responses
  always @(negedge clk) begin : issue
    logic [N-1:0] exp_r;
    int           g;
    #1;
    exp_r = '0;
    g     = -1;
    if (reset) begin
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL ready_in_reset: got %b expected 0 at %0t", req_ready, $time);
      end
      q.delete();
      mptr   = 0;
      mgrant = -1;
    end else begin
      if (enable) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
        end
      end
      if (g >= 0) exp_r[g] = 1'b1;
      checks++;
      if (req_ready !== exp_r) begin
        errors++;
        $display("FAIL grant: got %b expected %b at %0t", req_ready, exp_r, $time);
      end
      if (enable) begin
        foreach (q[i]) if (q[i].cnt > 0) q[i].cnt--;
        if (g >= 0) begin
          q.push_back('{id: g, data: ref_op(op_a[g], lhs_a[g], rhs_a[g]), cnt: Lat - 1});
          mptr = (g + 1) % N;
        end
      end
      mgrant = g;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (mgrant >= 0) req_valid[mgrant] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_valid[i] = 1'b1;
    op_a[i]      = o;
    lhs_a[i]     = a;
    rhs_a[i]     = b;
  endtask

  task automatic rand_req(input int i);
    logic [W-1:0] b;
    b = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 40));
    set_req(i, 4'($urandom_range(0, 15)), W'($urandom), b);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i]  = '0;
      lhs_a[i] = '0;
      rhs_a[i] = '0;
    end
    repeat (3) step();
    reset = 1'b0;

    // All requesters contend for 8 cycles: strict rotation from 0
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i]) rand_req(i);
      step();
    end
    req_valid = '0;
    repeat (4) step();

    // Single request
    set_req(2, 4'd0, 32'd5, 32'd7);
    repeat (5) step();

    // Arithmetic corners
    set_req(0, 4'd1, 32'h0, 32'h1);
    set_req(1, 4'd2, 32'h0001_0000, 32'h0001_0000);
    set_req(2, 4'd4, 32'h8000_0000, 32'd40);
    set_req(3, 4'd3, 32'h8000_0000, 32'd31);
    repeat (4) step();
    set_req(0, 4'd12, 32'hdead_beef, 32'h1234_5678);
    set_req(1, 4'd5, 32'h1, 32'd32);
    repeat (5) step();

    // Enable stall after an accept, with another request pending
    set_req(1, 4'd0, 32'd100, 32'd23);
    step();
    enable = 1'b0;
    set_req(3, 4'd1, 32'd1, 32'd2);
    repeat (3) step();
    enable = 1'b1;
    repeat (6) step();

    // Reset while an operation is in flight
    for (int i = 0; i < N; i++) rand_req(i);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) if (!req_valid[i]) rand_req(i);
    repeat (6) step();
    req_valid = '0;
    repeat (4) step();

    // Randomized traffic with stalls and occasional resets
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          rand_req(i);
        end
      end
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 99) == 0);
      step();
    end

    reset     = 1'b0;
    enable    = 1'b1;
    req_valid = '0;
    repeat (Lat + 4) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
